// File: rtl/uart_tx_arb.sv
// Round-robin, packet-locked arbiter feeding one UART transmitter through a one-byte stage.
// Define UART_TX_ARB_TAG_EN to prefix every packet with the tag byte 8'hA0 | grant.
module uart_tx_arb #(
  parameter int N_SRC = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_SRC-1:0]   src_valid,
  input  logic [8*N_SRC-1:0] src_data,
  input  logic [N_SRC-1:0]   src_last,
  output logic [N_SRC-1:0]   src_ready,
  output logic               fifordempty,
  output logic [7:0]         fifodata,
  input  logic               fifordreq,
  output logic [1:0]         grant,
  output logic               busy,
  output logic               underrun
);

`ifdef UART_TX_ARB_TAG_EN
  typedef enum logic [1:0] {ST_IDLE, ST_TAG, ST_DATA} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_DATA} state_t;
`endif

  state_t      state;
  logic [1:0]  rr_ptr;
  logic [7:0]  stg_data;
  logic        stg_vld;
  logic [3:0]  valid_pad;
  logic [3:0]  last_pad;
  logic [7:0]  data_arr [4];
  logic        stage_free;
  logic        drain;
  logic        take;
  logic        any_req;
  logic [1:0]  pick;

  // Widen the per-source buses to four lanes so a 2-bit grant always indexes in range.
  always_comb begin
    valid_pad = '0;
    last_pad  = '0;
    for (int i = 0; i < 4; i++) data_arr[i] = '0;
    for (int i = 0; i < N_SRC; i++) begin
      valid_pad[i] = src_valid[i];
      last_pad[i]  = src_last[i];
      data_arr[i]  = src_data[8*i +: 8];
    end
  end

  always_comb begin
    pick    = rr_ptr;
    any_req = 1'b0;
    for (int k = 1; k <= N_SRC; k++) begin
      if (!any_req && valid_pad[2'((int'(rr_ptr) + k) % N_SRC)]) begin
        pick    = 2'((int'(rr_ptr) + k) % N_SRC);
        any_req = 1'b1;
      end
    end
  end

  assign stage_free  = ~stg_vld | fifordreq;
  assign drain       = fifordreq & stg_vld;
  assign take        = (state == ST_DATA) & valid_pad[grant] & stage_free;
  assign fifordempty = ~stg_vld;
  assign busy        = (state != ST_IDLE) | stg_vld;

  always_comb begin
    src_ready = '0;
    if (state == ST_DATA) begin
      for (int i = 0; i < N_SRC; i++) begin
        if (grant == 2'(i)) src_ready[i] = stage_free;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      grant    <= '0;
      rr_ptr   <= 2'(N_SRC - 1);
      stg_data <= '0;
      stg_vld  <= 1'b0;
      fifodata <= '0;
      underrun <= 1'b0;
    end else begin
      if (drain) fifodata <= stg_data;
      if (fifordreq && !stg_vld) underrun <= 1'b1;
      // A load below in the same cycle overrides this clear (drain + refill).
      if (drain) stg_vld <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            grant <= pick;
`ifdef UART_TX_ARB_TAG_EN
            state <= ST_TAG;
`else
            state <= ST_DATA;
`endif
          end
        end
`ifdef UART_TX_ARB_TAG_EN
        ST_TAG: begin
          if (stage_free) begin
            stg_data <= 8'hA0 | {6'b0, grant};
            stg_vld  <= 1'b1;
            state    <= ST_DATA;
          end
        end
`endif
        ST_DATA: begin
          if (take) begin
            stg_data <= data_arr[grant];
            stg_vld  <= 1'b1;
            if (last_pad[grant]) begin
              rr_ptr <= grant;
              state  <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
